// File: rtl/iterative_comparator_pkg.sv
// Shared types for the chunk-serial magnitude comparator.
package iterative_comparator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  typedef struct packed {
    logic lte;
    logic gte;
  } cmp_range_t;

  localparam cmp_result_t CmpEqual = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};

  function automatic cmp_range_t cmp_range(input cmp_result_t r);
    cmp_range_t o;
    o.lte = r.lt | r.eq;
    o.gte = r.gt | r.eq;
    return o;
  endfunction

endpackage

// File: rtl/iterative_comparator_chunk_compare.sv
// Combinational unsigned compare of one operand chunk.
module chunk_compare #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/iterative_comparator.sv
// Multi-cycle comparator: walks operands MSB chunk first, with valid/ready on both sides.
module iterative_comparator
  import iterative_comparator_pkg::*;
#(
  parameter int unsigned BW         = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          eq,
  output logic          lt,
  output logic          gt,
  output logic          lte,
  output logic          gte
);

  localparam int unsigned NCHUNK = BW / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  cmp_state_e  state_q, state_d;
  logic [BW-1:0] a_q, a_d, b_q, b_d;
  logic [BW-1:0] a_shift, b_shift;
  logic [KW-1:0] k_q, k_d;
  cmp_result_t res_q, res_d;
  logic        diff_q, diff_d;

  logic        c_eq, c_gt;
  logic        found;
  cmp_result_t r_cur;

  // Operands are shifted left each cycle so the active chunk is always the top one.
  chunk_compare #(
    .Width (CHUNK)
  ) u_chunk_compare (
    .a_i  (a_q[BW-1 -: CHUNK]),
    .b_i  (b_q[BW-1 -: CHUNK]),
    .eq_o (c_eq),
    .gt_o (c_gt)
  );

  if (NCHUNK > 1) begin : g_shift
    assign a_shift = {a_q[BW-CHUNK-1:0], {CHUNK{1'b0}}};
    assign b_shift = {b_q[BW-CHUNK-1:0], {CHUNK{1'b0}}};
  end else begin : g_no_shift
    assign a_shift = a_q;
    assign b_shift = b_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    diff_d  = diff_q;
    found   = diff_q;
    r_cur   = res_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d         = in_a;
          b_d         = in_b;
          a_d[BW-1]   = in_a[BW-1] ^ in_signed;
          b_d[BW-1]   = in_b[BW-1] ^ in_signed;
          k_d         = KW'(NCHUNK - 1);
          diff_d      = 1'b0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (!diff_q && !c_eq) begin
          found = 1'b1;
          r_cur = '{eq: 1'b0, lt: ~c_gt, gt: c_gt};
        end
        if (EARLY_EXIT && !c_eq) begin
          res_d   = r_cur;
          state_d = StDone;
        end else if (k_q == '0) begin
          res_d   = found ? r_cur : CmpEqual;
          state_d = StDone;
        end else begin
          res_d  = r_cur;
          diff_d = found;
          k_d    = k_q - 1'b1;
          a_d    = a_shift;
          b_d    = b_shift;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      diff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
    end
  end

  cmp_range_t range;
  assign range = cmp_range(res_q);

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign eq        = res_q.eq;
  assign lt        = res_q.lt;
  assign gt        = res_q.gt;
  assign lte       = range.lte;
  assign gte       = range.gte;

endmodule

// File: tb/tb_iterative_comparator.sv
// Directed and light random checks of iterative_comparator in three configurations.
module tb_iterative_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [31:0] in_a, in_b;
  logic        in_signed;
  logic [2:0]  ir, ov, feq, flt, fgt, flte, fgte;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: 32/8 early exit, 1: 32/8 constant latency, 2: 8/8 single chunk
  iterative_comparator #(.BW(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov[0]), .out_ready(out_ready[0]), .eq(feq[0]),
    .lt(flt[0]), .gt(fgt[0]), .lte(flte[0]), .gte(fgte[0])
  );

  iterative_comparator #(.BW(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov[1]), .out_ready(out_ready[1]), .eq(feq[1]),
    .lt(flt[1]), .gt(fgt[1]), .lte(flte[1]), .gte(fgte[1])
  );

  iterative_comparator #(.BW(8), .CHUNK(8), .EARLY_EXIT(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir[2]), .in_a(in_a[7:0]),
    .in_b(in_b[7:0]), .in_signed(in_signed), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .eq(feq[2]), .lt(flt[2]), .gt(fgt[2]), .lte(flte[2]), .gte(fgte[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expf = {eq, lt, gt, lte, gte}
  task automatic xact(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [4:0] expf, input int explat, input int hold);
    int lat;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid[sel] = 1'b1;
    out_ready[sel] = 1'b0;
    chk("in_ready_idle", 32'(ir[sel]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_a = ~a;
    in_b = a;
    in_signed = ~s;
    chk("in_ready_busy", 32'(ir[sel]), 32'd0);
    lat = 0;
    while (!ov[sel] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(explat));
    chk("flags", 32'({feq[sel], flt[sel], fgt[sel], flte[sel], fgte[sel]}), 32'(expf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(ov[sel]), 32'd1);
      chk("hold_ready", 32'(ir[sel]), 32'd0);
      chk("hold_flags", 32'({feq[sel], flt[sel], fgt[sel], flte[sel], fgte[sel]}), 32'(expf));
    end
    @(negedge clk);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    chk("post_hs_valid", 32'(ov[sel]), 32'd0);
    chk("post_hs_ready", 32'(ir[sel]), 32'd1);
  endtask

  function automatic logic [4:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
    logic e, l, g;
    e = (a == b);
    l = s ? ($signed(a) < $signed(b)) : (a < b);
    g = !e && !l;
    return {e, l, g, l | e, g | e};
  endfunction

  function automatic int model_lat_early(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    for (int c = 3; c >= 0; c--) begin
      if (x[c*8 +: 8] != 8'h00) return 4 - c;
    end
    return 4;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_a = '0;
    in_b = '0;
    in_signed = 1'b0;
    #12;
    chk("reset_in_ready", 32'(ir), 32'd0);
    chk("reset_out_valid", 32'(ov), 32'd0);
    chk("reset_flags", 32'({feq, flt, fgt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(ir), 32'h7);

    // Early-exit configuration
    xact(0, 32'h12345678, 32'h12345679, 1'b0, 5'b01010, 4, 0);
    xact(0, 32'hFF000000, 32'h01000000, 1'b0, 5'b00101, 1, 0);
    xact(0, 32'hFF000000, 32'h01000000, 1'b1, 5'b01010, 1, 0);
    xact(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'b10011, 4, 3);
    xact(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'b10011, 4, 0);
    xact(0, 32'h00120000, 32'h00110000, 1'b1, 5'b00101, 2, 0);

    // Constant-latency configuration
    xact(1, 32'h80000000, 32'h00000000, 1'b0, 5'b00101, 4, 0);
    xact(1, 32'h80000000, 32'h00000000, 1'b1, 5'b01010, 4, 2);
    xact(1, 32'h12345678, 32'h12345679, 1'b0, 5'b01010, 4, 0);
    xact(1, 32'h01FF0000, 32'h02000000, 1'b0, 5'b01010, 4, 0);

    // Single-chunk configuration
    xact(2, 32'h0000007F, 32'h00000080, 1'b0, 5'b01010, 1, 0);
    xact(2, 32'h0000007F, 32'h00000080, 1'b1, 5'b00101, 1, 0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    in_a = 32'h00000001;
    in_b = 32'h00000002;
    in_signed = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(ov[0]), 32'd0);
    chk("abort_in_ready", 32'(ir[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_reset_ready", 32'(ir[0]), 32'd1);
    xact(0, 32'd5, 32'd5, 1'b0, 5'b10011, 4, 0);

    // Random regression on both 32-bit configurations
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case (i % 3)
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(1, 0));
      xact(0, ra, rb, rs, model_flags(ra, rb, rs), model_lat_early(ra, rb), 0);
      xact(1, ra, rb, rs, model_flags(ra, rb, rs), 4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_comparator.md
Name: iterative_comparator

Overview:
- Multi-cycle, chunk-serial magnitude comparator with a valid/ready handshake on input and output.
- Compares two BW-bit operands CHUNK bits per cycle, starting at the MSB chunk, in signed or unsigned mode chosen per transaction.
- Produces registered eq/lt/gt/lte/gte flags.
- Parametrised successor to the combinational comparator. Trades latency for area on wide operands and adds optional early termination.

Parameters:
- BW, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per cycle; NCHUNK = BW/CHUNK, NCHUNK >= 1.
- EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always examine all NCHUNK chunks (constant latency).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept a transaction.
- in_a  input  BW  operand a.
- in_b  input  BW  operand b.
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer accepts result.
- eq  output  1  a == b.
- lt  output  1  a < b.
- gt  output  1  a > b.
- lte  output  1  a <= b.
- gte  output  1  a >= b.

Behaviour:
- The clock is clk. Reset rst is asynchronous and active-high. While rst is high: state = IDLE, out_valid = 0, all flags = 0, in_ready = 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - Accept happens on a rising edge with in_valid && in_ready.
  - On accept: latch a, b and in_signed; chunk index k = NCHUNK-1; go to BUSY.
- Signed mode: invert bit BW-1 of both latched operands at capture. The unsigned chunk compare then gives the signed ordering.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle compares chunk k of a and b, i.e. bits [k*CHUNK +: CHUNK].
  - Chunk differs and EARLY_EXIT = 1: register gt = (chunk_a > chunk_b), lt = !gt, eq = 0; go to DONE.
  - Chunk differs and EARLY_EXIT = 0: record the first differing result, keep the recorded value, and continue.
  - k == 0: finalise. If no difference was recorded: eq = 1, lt = gt = 0. Go to DONE.
  - Otherwise decrement k.
- DONE:
  - out_valid = 1; flags held stable; lte = lt | eq; gte = gt | eq.
  - On out_valid && out_ready, go to IDLE at that edge; out_valid drops on the next cycle.
  - No new accept occurs in the same cycle as the output handshake.
- Latency: out_valid rises n edges after the accept edge.
  - EARLY_EXIT = 1: n = number of chunks examined, range 1..NCHUNK.
  - EARLY_EXIT = 0: n = NCHUNK.
- Flag invariant when out_valid = 1: exactly one of eq/lt/gt is set. While out_valid = 0 the flag values are don't-care, but they must not glitch during DONE.
- Backpressure: DONE holds indefinitely while out_ready = 0.
- Reset while BUSY or DONE aborts the transaction; no result is produced.
- in_valid and operand changes while in_ready = 0 are ignored.
- NCHUNK = 1 degenerates to a fixed 1-cycle latency.

Decomposition:
- Package iterative_comparator_pkg:
  - cmp_state_e enum (IDLE, BUSY, DONE).
  - cmp_result_t packed struct {eq, lt, gt}.
  - Function deriving lte/gte from cmp_result_t.
- Sub-module chunk_compare: purely combinational, CHUNK-bit unsigned compare with outputs eq and gt.
- The top level holds the FSM, operand registers, chunk index counter and result register.

Test Plan (BW=32, CHUNK=8 unless stated):
- Unsigned, a=0x12345678, b=0x12345679, EARLY_EXIT=1 -> lt=1, lte=1, eq=gt=gte=0; out_valid 4 edges after accept.
- Unsigned, a=0xFF000000, b=0x01000000 -> gt=1, gte=1; latency 1. Same operands with in_signed=1 (-16777216 vs 16777216) -> lt=1, lte=1; latency 1.
- a=b=0xDEADBEEF, unsigned then signed -> eq=lte=gte=1, lt=gt=0; latency 4 both times. Repeat with EARLY_EXIT=0 and a=0x80000000, b=0 -> gt=1 unsigned / lt=1 signed; latency 4.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and flags stable, in_ready=0. Raise out_ready -> handshake; in_ready=1 the following cycle. A second back-to-back transaction then completes correctly.
- Assert rst asynchronously mid-BUSY (a=0x00000001, b=0x00000002) -> out_valid=0 and in_ready=0 immediately. After deassert, in_ready=1, and a fresh compare of 5 vs 5 gives eq=1.
- NCHUNK=1 (BW=8, CHUNK=8), a=0x7F, b=0x80 -> unsigned lt=1, signed gt=1; latency 1. Random regression against a golden model checks flags and latency bounds.
